// File: rtl/seq_detect_sched_if.sv
// ---------------------------------------------------------------------------
// seq_detect_sched_if
//   Request-side bus between the serial front-ends and the shared run-of-ones
//   detector scheduler.
//
//   req_valid[NCH] : per-channel bit valid            (front-end -> scheduler)
//   req_bit[NCH]   : per-channel serial bit           (front-end -> scheduler)
//   ch_clear[NCH]  : per-channel context clear        (front-end -> scheduler)
//   req_ready[NCH] : one-hot grant, bit accepted on valid & ready
//
//   modport master : front-end side (drives valid/bit/clear)
//   modport slave  : scheduler side (drives ready)
// ---------------------------------------------------------------------------
interface seq_detect_sched_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] req_valid;
  logic [NCH-1:0] req_bit;
  logic [NCH-1:0] ch_clear;
  logic [NCH-1:0] req_ready;

  modport master (
    output req_valid,
    output req_bit,
    output ch_clear,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_bit,
    input  ch_clear,
    output req_ready
  );
endinterface

// File: rtl/seq_detect_sched.sv
// ---------------------------------------------------------------------------
// seq_detect_sched
//   Time-multiplexed round-robin scheduler for one shared run-of-ones detector
//   serving NCH serial channels. At most one bit per cycle is accepted; the
//   granted channel's run count is advanced and written back, and a registered
//   one-cycle match event is raised when a run first reaches the programmed
//   length.
//
//   Optional feature macro: SEQDET_MATCH_CNT_EN
//     defined   : per-channel saturating match counters, readable via
//                 i_rd_ch / o_rd_cnt with one cycle of latency
//     undefined : no counters, o_rd_cnt tied to 0, i_rd_ch ignored
//
// Ports
//   i_clk          : clock, all state on rising edge
//   i_rst          : asynchronous active-high reset
//   i_cfg_en       : scheduler enable (0 = no grants)
//   i_cfg_run_len  : required run length (0 = detection disabled)
//   bus            : request bus (valid / bit / clear in, one-hot ready out)
//   o_match_valid  : one-cycle match pulse
//   o_match_ch     : channel of the match
//   o_busy         : any request valid while enabled
//   i_rd_ch        : match-counter read select
//   o_rd_cnt       : match-counter read data
// ---------------------------------------------------------------------------
module seq_detect_sched #(
  parameter int NCH = 4,
  parameter int CW  = 4,
  parameter int MCW = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cfg_en,
  input  logic [CW-1:0]            i_cfg_run_len,
  seq_detect_sched_if.slave        bus,
  output logic                     o_match_valid,
  output logic [$clog2(NCH)-1:0]   o_match_ch,
  output logic                     o_busy,
  input  logic [$clog2(NCH)-1:0]   i_rd_ch,
  output logic [MCW-1:0]           o_rd_cnt
);

  localparam int CHW = $clog2(NCH);

  logic [CW-1:0]  r_run [NCH];
  logic [CHW-1:0] r_rr;
  logic [CW-1:0]  r_len_q;
  logic           r_en_q;
  logic           r_match_valid;
  logic [CHW-1:0] r_match_ch;

  logic [NCH-1:0] w_elig;
  logic [NCH-1:0] w_gnt;
  logic           w_gnt_found;
  logic [CHW-1:0] w_gnt_idx;
  logic [CHW-1:0] w_rr_next;
  logic [CW-1:0]  w_run_sel;
  logic [CW:0]    w_run_inc;
  logic [CW-1:0]  w_run_next;
  logic           w_bit_sel;
  logic           w_match;
  logic           w_en_rise;

  // Grants wait one cycle after enable so the context wipe on the enable
  // edge never races with an accepted bit.
  assign w_elig    = bus.req_valid & ~bus.ch_clear & {NCH{i_cfg_en & r_en_q}};
  assign w_en_rise = i_cfg_en & ~r_en_q;

  // Round-robin search starting at the pointer, wrapping NCH-1 -> 0.
  always_comb begin
    int idx;
    idx         = 0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_gnt       = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!w_gnt_found && w_elig[idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = CHW'(idx);
      end
    end
    if (w_gnt_found) w_gnt[w_gnt_idx] = 1'b1;
  end

  assign w_rr_next  = (w_gnt_idx == CHW'(NCH - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_run_sel  = r_run[w_gnt_idx];
  assign w_bit_sel  = bus.req_bit[w_gnt_idx];
  assign w_run_inc  = {1'b0, w_run_sel} + (CW+1)'(1);
  // Saturate after the compare so a length of 2^CW-1 is still reachable.
  assign w_run_next = (&w_run_sel) ? w_run_sel : w_run_inc[CW-1:0];
  // Equality (not >=) makes the event fire once per run.
  assign w_match    = w_gnt_found & w_bit_sel & (r_len_q != '0) &
                      (w_run_inc == {1'b0, r_len_q});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NCH; i++) r_run[i] <= '0;
      r_rr          <= '0;
      r_len_q       <= '0;
      r_en_q        <= 1'b0;
      r_match_valid <= 1'b0;
      r_match_ch    <= '0;
    end else begin
      r_en_q        <= i_cfg_en;
      r_match_valid <= w_match;
      if (!i_cfg_en)   r_len_q    <= i_cfg_run_len;
      if (w_gnt_found) r_rr       <= w_rr_next;
      if (w_match)     r_match_ch <= w_gnt_idx;
      for (int i = 0; i < NCH; i++) begin
        if (w_en_rise || bus.ch_clear[i]) r_run[i] <= '0;
        else if (w_gnt[i])                r_run[i] <= w_bit_sel ? w_run_next : '0;
      end
    end
  end

  assign bus.req_ready = w_gnt;
  assign o_match_valid = r_match_valid;
  assign o_match_ch    = r_match_ch;
  assign o_busy        = i_cfg_en & (|bus.req_valid);

`ifdef SEQDET_MATCH_CNT_EN
  logic [MCW-1:0] r_cnt [NCH];
  logic [MCW-1:0] r_rd_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
      r_rd_cnt <= '0;
    end else begin
      r_rd_cnt <= (int'(i_rd_ch) < NCH) ? r_cnt[i_rd_ch] : '0;
      for (int i = 0; i < NCH; i++) begin
        if (bus.ch_clear[i])                          r_cnt[i] <= '0;
        else if (w_match && w_gnt[i] && !(&r_cnt[i])) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign o_rd_cnt = r_rd_cnt;
`else
  logic w_rd_ch_unused;
  assign w_rd_ch_unused = ^i_rd_ch;
  assign o_rd_cnt       = '0;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
module tb_seq_detect_sched;
  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int MCW = 8;
`ifdef SEQDET_MATCH_CNT_EN
  localparam int EXP_CNT3 = 3;
`else
  localparam int EXP_CNT3 = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_en = 1'b0;
  logic [CW-1:0]  cfg_run_len = '0;
  logic [1:0]     rd_ch = '0;
  logic           match_valid;
  logic [1:0]     match_ch;
  logic           busy;
  logic [MCW-1:0] rd_cnt;

  seq_detect_sched_if #(.NCH(NCH)) bus();

  seq_detect_sched #(.NCH(NCH), .CW(CW), .MCW(MCW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cfg_en      (cfg_en),
    .i_cfg_run_len (cfg_run_len),
    .bus           (bus.slave),
    .o_match_valid (match_valid),
    .o_match_ch    (match_ch),
    .o_busy        (busy),
    .i_rd_ch       (rd_ch),
    .o_rd_cnt      (rd_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state (integer view of the scheduler's observable rules)
  int m_run [NCH];
  int m_cnt [NCH];
  int m_rr, m_len, m_en_q, m_mv, m_mch, m_rd;

  int obs_rdy, obs_mv, obs_mch;

  typedef struct {
    logic [NCH-1:0] v;
    logic [NCH-1:0] b;
    logic [NCH-1:0] rdy;
    logic           mv;
    int             mch;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mreset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0;
      m_cnt[i] = 0;
    end
    m_rr = 0; m_len = 0; m_en_q = 0; m_mv = 0; m_mch = 0; m_rd = 0;
  endfunction

  function automatic int mgrant(input logic [NCH-1:0] v, input logic [NCH-1:0] c);
    if (!(cfg_en && m_en_q != 0)) return -1;
    for (int k = 0; k < NCH; k++) begin
      int i;
      i = (m_rr + k) % NCH;
      if (v[i] && !c[i]) return i;
    end
    return -1;
  endfunction

  function automatic void mstep(input logic [NCH-1:0] b, input logic [NCH-1:0] c, input int g);
    int nmv;
    nmv = (g >= 0 && b[g] && m_len != 0 && m_run[g] + 1 == m_len) ? 1 : 0;
`ifdef SEQDET_MATCH_CNT_EN
    m_rd = m_cnt[rd_ch];
    for (int i = 0; i < NCH; i++) if (c[i]) m_cnt[i] = 0;
    if (nmv != 0 && m_cnt[g] < 255) m_cnt[g] = m_cnt[g] + 1;
`else
    m_rd = 0;
`endif
    if (nmv != 0) m_mch = g;
    m_mv = nmv;
    if (cfg_en && m_en_q == 0) begin
      for (int i = 0; i < NCH; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < NCH; i++) if (c[i]) m_run[i] = 0;
      if (g >= 0) m_run[g] = b[g] ? ((m_run[g] < 15) ? m_run[g] + 1 : 15) : 0;
    end
    if (!cfg_en) m_len = int'(cfg_run_len);
    m_en_q = cfg_en ? 1 : 0;
    if (g >= 0) m_rr = (g + 1) % NCH;
  endfunction

  // One clock cycle: apply inputs, compare against the model, advance.
  task automatic cycle(input logic [NCH-1:0] v, input logic [NCH-1:0] b, input logic [NCH-1:0] c);
    int g;
    bus.req_valid = v;
    bus.req_bit   = b;
    bus.ch_clear  = c;
    #1;
    g = mgrant(v, c);
    chk("req_ready", int'(bus.req_ready), (g < 0) ? 0 : (1 << g));
    chk("busy", int'(busy), (cfg_en && v != 0) ? 1 : 0);
    chk("match_valid", int'(match_valid), m_mv);
    if (m_mv != 0) chk("match_ch", int'(match_ch), m_mch);
    chk("rd_cnt", int'(rd_cnt), m_rd);
    obs_rdy = int'(bus.req_ready);
    obs_mv  = int'(match_valid);
    obs_mch = int'(match_ch);
    @(posedge clk);
    mstep(b, c, g);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cfg_en = 1'b0;
    bus.req_valid = '0;
    bus.req_bit   = '0;
    bus.ch_clear  = '0;
    mreset();
    @(posedge clk);
    #1;
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_match_valid", int'(match_valid), 0);
    chk("rst_rd_cnt", int'(rd_cnt), 0);
    rst = 1'b0;
  endtask

  task automatic enable(input int len);
    cfg_en = 1'b0;
    cfg_run_len = CW'(len);
    cycle('0, '0, '0);
    cfg_en = 1'b1;
    cycle('0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int npulse, tfirst;
    bus.req_valid = '0;
    bus.req_bit   = '0;
    bus.ch_clear  = '0;

    tbl[0] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 0};
    tbl[1] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 0};
    tbl[2] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 0};
    tbl[3] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 0};
    tbl[4] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 0};
    tbl[5] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 0};
    tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 0};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 0};

    // Channel 0 alone, length 2, bits 1,1,1,0,1,1
    apply_reset();
    enable(2);
    for (int r = 0; r < 8; r++) begin
      cycle(tbl[r].v, tbl[r].b, '0);
      chk("tbl_ready", obs_rdy, int'(tbl[r].rdy));
      chk("tbl_mv", obs_mv, int'(tbl[r].mv));
      if (tbl[r].mv) chk("tbl_mch", obs_mch, tbl[r].mch);
    end

    // All channels streaming ones, length 3
    apply_reset();
    enable(3);
    for (int t = 0; t < 16; t++) begin
      cycle(4'b1111, 4'b1111, '0);
      chk("all_gnt", obs_rdy, 1 << (t % 4));
      chk("all_mv", obs_mv, (t >= 9 && t <= 12) ? 1 : 0);
      if (t >= 9 && t <= 12) chk("all_mch", obs_mch, t - 9);
    end

    // ch_clear on channel 1 while it would be granted
    apply_reset();
    enable(2);
    for (int t = 0; t < 8; t++) begin
      cycle(4'b0110, 4'b0110, (t == 2) ? 4'b0010 : 4'b0000);
      if (t == 2) chk("clr_gnt", obs_rdy, 4'b0100);
      chk("clr_mv", obs_mv, (t == 3 || t == 6) ? 1 : 0);
      if (t == 3) chk("clr_mch", obs_mch, 2);
      if (t == 6) chk("clr_mch", obs_mch, 1);
    end

    // Length 0 and length 15 with 20 consecutive ones
    for (int s = 0; s < 2; s++) begin
      apply_reset();
      enable((s == 0) ? 0 : 15);
      npulse = 0;
      tfirst = -1;
      for (int t = 0; t < 22; t++) begin
        cycle((t < 20) ? 4'b0001 : 4'b0000, (t < 20) ? 4'b0001 : 4'b0000, '0);
        if (obs_mv != 0) begin
          npulse++;
          if (tfirst < 0) tfirst = t;
        end
      end
      chk("len_npulse", npulse, (s == 0) ? 0 : 1);
      if (s == 1) chk("len15_time", tfirst, 15);
    end

    // Reset with a match pending in the output register
    apply_reset();
    enable(1);
    cycle(4'b0001, 4'b0001, '0);
    rst = 1'b1;
    #1;
    chk("mid_rst_mv", int'(match_valid), 0);
    chk("mid_rst_ready", int'(bus.req_ready), 0);
    mreset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cfg_en = 1'b0;
    enable(2);
    for (int t = 0; t < 6; t++) cycle(4'b1111, 4'b1111, '0);

    // Match counters on channel 2
    apply_reset();
    enable(1);
    rd_ch = 2'd2;
    cycle(4'b0100, 4'b0100, '0);
    cycle(4'b0100, 4'b0000, '0);
    cycle(4'b0100, 4'b0100, '0);
    cycle(4'b0100, 4'b0000, '0);
    cycle(4'b0100, 4'b0100, '0);
    cycle('0, '0, '0);
    cycle('0, '0, '0);
    chk("cnt3", int'(rd_cnt), EXP_CNT3);
    cycle('0, '0, 4'b0100);
    cycle('0, '0, '0);
    chk("cnt_clr", int'(rd_cnt), 0);

    // Randomized traffic against the model
    apply_reset();
    enable($urandom_range(1, 4));
    for (int n = 0; n < 2000; n++) begin
      logic [NCH-1:0] v, b, c;
      if ($urandom_range(0, 99) == 0) begin
        cfg_en = ~cfg_en;
        if (!cfg_en) cfg_run_len = CW'($urandom_range(0, 5));
      end
      rd_ch = 2'($urandom_range(0, NCH - 1));
      v = NCH'($urandom);
      b = NCH'($urandom | $urandom);
      c = ($urandom_range(0, 7) == 0) ? NCH'(1 << $urandom_range(0, NCH - 1)) : '0;
      cycle(v, b, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
